axi_stream_rx_fifo: RTL and testbench

Parametrised AXI-Stream receive buffer: accepts beats from the system-side stream and presents them to the internal datapath (MAC/hash core) through a first-word-fall-through FIFO of configurable depth. It carries TLAST/TKEEP sideband, keeps a registered TREADY toward the system, counts completed packets and flags system-side protocol violations. It sits between the external AXI-Stream source and the authentication core input.

---
 rtl/axi_stream_rx_fifo.sv | 153 +++++++++++++++
 tb/tb_axi_stream_rx_fifo.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_stream_rx_fifo.sv
// ---------------------------------------------------------------------------
// axi_stream_rx_fifo
//
// AXI-Stream receive buffer between the external stream source and the
// authentication core input. Beats are held in a first-word-fall-through
// FIFO of DEPTH entries together with their TKEEP/TLAST sideband.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   s_valid    system-side TVALID
//   s_ready    system-side TREADY (registered)
//   s_data     system-side TDATA
//   s_keep     system-side TKEEP
//   s_last     system-side TLAST
//   m_valid    internal-side valid, high while the FIFO holds data
//   m_ready    internal-side ready
//   m_data     head-entry data (fall-through)
//   m_keep     head-entry keep (fall-through)
//   m_last     head-entry last (fall-through)
//   level      current occupancy, 0..DEPTH
//   pkt_count  packets delivered (m_last handshakes), wraps
//   proto_err  sticky flag: s_valid withdrawn before its handshake
// ---------------------------------------------------------------------------
module axi_stream_rx_fifo #(
    parameter int DATA_WIDTH = 512,
    parameter int DEPTH      = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [DATA_WIDTH-1:0]        s_data,
    input  logic [DATA_WIDTH/8-1:0]      s_keep,
    input  logic                         s_last,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [DATA_WIDTH-1:0]        m_data,
    output logic [DATA_WIDTH/8-1:0]      m_keep,
    output logic                         m_last,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic [CNT_WIDTH-1:0]         pkt_count,
    output logic                         proto_err
);

    localparam int KEEP_WIDTH = DATA_WIDTH / 8;
    localparam int PTR_WIDTH  = $clog2(DEPTH);
    localparam int LVL_WIDTH  = $clog2(DEPTH + 1);

    // Storage is deliberately left unreset; only entries between rptr and
    // wptr are ever observed while m_valid is high.
    logic [DATA_WIDTH-1:0] data_mem_r [DEPTH];
    logic [KEEP_WIDTH-1:0] keep_mem_r [DEPTH];
    logic                  last_mem_r [DEPTH];

    logic [PTR_WIDTH-1:0]  wptr_r;
    logic [PTR_WIDTH-1:0]  rptr_r;
    logic [LVL_WIDTH-1:0]  level_r;
    logic [LVL_WIDTH-1:0]  level_next_s;
    logic                  s_ready_r;
    logic                  m_valid_r;
    logic [CNT_WIDTH-1:0]  pkt_count_r;
    logic                  held_r;
    logic                  proto_err_r;
    logic                  push_s;
    logic                  pop_s;

    assign push_s = s_valid & s_ready_r;
    assign pop_s  = m_valid_r & m_ready;

    // Occupancy after the current edge; push and pop together cancel out.
    always_comb begin
        level_next_s = level_r;
        case ({push_s, pop_s})
            2'b10:   level_next_s = level_r + LVL_WIDTH'(1);
            2'b01:   level_next_s = level_r - LVL_WIDTH'(1);
            default: level_next_s = level_r;
        endcase
    end

    // Entry write on an accepted beat.
    always_ff @(posedge clk) begin
        if (push_s) begin
            data_mem_r[wptr_r] <= s_data;
            keep_mem_r[wptr_r] <= s_keep;
            last_mem_r[wptr_r] <= s_last;
        end else begin
            data_mem_r[wptr_r] <= data_mem_r[wptr_r];
            keep_mem_r[wptr_r] <= keep_mem_r[wptr_r];
            last_mem_r[wptr_r] <= last_mem_r[wptr_r];
        end
    end

    // Pointers, occupancy and the registered handshake flags.
    // m_valid is registered from level_next so it always equals (level != 0)
    // while staying a flop output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_r    <= PTR_WIDTH'(0);
            rptr_r    <= PTR_WIDTH'(0);
            level_r   <= LVL_WIDTH'(0);
            s_ready_r <= 1'b0;
            m_valid_r <= 1'b0;
        end else begin
            if (push_s) begin
                wptr_r <= wptr_r + PTR_WIDTH'(1);
            end else begin
                wptr_r <= wptr_r;
            end
            if (pop_s) begin
                rptr_r <= rptr_r + PTR_WIDTH'(1);
            end else begin
                rptr_r <= rptr_r;
            end
            level_r   <= level_next_s;
            s_ready_r <= (level_next_s < LVL_WIDTH'(DEPTH));
            m_valid_r <= (level_next_s != LVL_WIDTH'(0));
        end
    end

    // Delivered-packet counter, wraps naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pkt_count_r <= CNT_WIDTH'(0);
        end else if (pop_s && last_mem_r[rptr_r]) begin
            pkt_count_r <= pkt_count_r + CNT_WIDTH'(1);
        end else begin
            pkt_count_r <= pkt_count_r;
        end
    end

    // Protocol monitor: a beat offered but not taken must stay valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            held_r      <= 1'b0;
            proto_err_r <= 1'b0;
        end else begin
            held_r      <= s_valid & ~s_ready_r;
            proto_err_r <= proto_err_r | (held_r & ~s_valid);
        end
    end

    assign s_ready   = s_ready_r;
    assign m_valid   = m_valid_r;
    assign m_data    = data_mem_r[rptr_r];
    assign m_keep    = keep_mem_r[rptr_r];
    assign m_last    = last_mem_r[rptr_r];
    assign level     = level_r;
    assign pkt_count = pkt_count_r;
    assign proto_err = proto_err_r;

endmodule

// File: tb/tb_axi_stream_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_axi_stream_rx_fifo
//
// Self-checking bench for axi_stream_rx_fifo (DATA_WIDTH=32, DEPTH=4).
// Accepted beats are pushed to a scoreboard queue and compared on delivery;
// a reference model of level/ready/valid/pkt_count/proto_err is checked
// every cycle on the falling edge.
// ---------------------------------------------------------------------------
module tb_axi_stream_rx_fifo;

    localparam int DW = 32;
    localparam int KW = DW / 8;
    localparam int DP = 4;
    localparam int CW = 16;

    logic          clk;
    logic          reset;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic [KW-1:0] s_keep;
    logic          s_last;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic [KW-1:0] m_keep;
    logic          m_last;
    logic [2:0]    level;
    logic [CW-1:0] pkt_count;
    logic          proto_err;

    int total_cnt;
    int bad_cnt;

    // expected beat: {data, keep, last}
    logic [DW+KW:0] exp_q [$];

    int exp_level;
    bit exp_ready;
    int exp_pkt;
    bit exp_proto;
    bit exp_held;

    axi_stream_rx_fifo #(
        .DATA_WIDTH(DW),
        .DEPTH     (DP),
        .CNT_WIDTH (CW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .s_keep   (s_keep),
        .s_last   (s_last),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_keep   (m_keep),
        .m_last   (m_last),
        .level    (level),
        .pkt_count(pkt_count),
        .proto_err(proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat and hold it until accepted; returns cycles spent.
    task automatic send(input logic [DW-1:0] d, input logic [KW-1:0] k,
                        input logic l, output int cyc);
        bit acc;
        acc     = 1'b0;
        cyc     = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_keep  = k;
        s_last  = l;
        while (!acc && cyc < 50) begin
            @(negedge clk);
            acc = s_ready;
            @(posedge clk);
            #1;
            cyc++;
        end
        if (!acc) check_val("send_timeout", {63'd0, acc}, 64'd1);
    endtask

    // Reference model and scoreboard, evaluated mid-cycle.
    initial begin
        bit push;
        bit pop;
        logic [DW+KW:0] e;
        forever begin
            @(negedge clk);
            if (reset) begin
                exp_q.delete();
                exp_level = 0;
                exp_ready = 1'b0;
                exp_pkt   = 0;
                exp_proto = 1'b0;
                exp_held  = 1'b0;
                check_val("rst_s_ready", {63'd0, s_ready}, 64'd0);
                check_val("rst_m_valid", {63'd0, m_valid}, 64'd0);
            end else begin
                check_val("s_ready",   {63'd0, s_ready},   {63'd0, exp_ready});
                check_val("m_valid",   {63'd0, m_valid},   {63'd0, exp_level != 0});
                check_val("level",     {61'd0, level},     64'(exp_level));
                check_val("pkt_count", {48'd0, pkt_count}, 64'(exp_pkt));
                check_val("proto_err", {63'd0, proto_err}, {63'd0, exp_proto});
                pop  = (exp_level != 0) && m_ready;
                push = s_valid && exp_ready;
                if (pop) begin
                    if (exp_q.size() == 0) begin
                        check_val("sb_underflow", 64'(exp_q.size()), 64'd1);
                    end else begin
                        e = exp_q.pop_front();
                        check_val("m_data", {32'd0, m_data}, {32'd0, e[DW+KW:KW+1]});
                        check_val("m_keep", {60'd0, m_keep}, {60'd0, e[KW:1]});
                        check_val("m_last", {63'd0, m_last}, {63'd0, e[0]});
                        if (e[0]) exp_pkt = (exp_pkt + 1) % 65536;
                    end
                end
                if (push) exp_q.push_back({s_data, s_keep, s_last});
                exp_level = exp_level + int'(push) - int'(pop);
                exp_proto = exp_proto | (exp_held & ~s_valid);
                exp_held  = s_valid & ~exp_ready;
                exp_ready = (exp_level < DP);
            end
        end
    end

    initial begin
        int cyc;
        int sum;
        total_cnt = 0;
        bad_cnt   = 0;
        reset     = 1'b1;
        s_valid   = 1'b0;
        s_data    = '0;
        s_keep    = '0;
        s_last    = 1'b0;
        m_ready   = 1'b0;

        // reset and release
        repeat (3) tick();
        check_val("in_reset_ready", {63'd0, s_ready}, 64'd0);
        reset = 1'b0;
        check_val("release_ready0", {63'd0, s_ready}, 64'd0);
        tick();
        check_val("release_ready1", {63'd0, s_ready}, 64'd1);
        check_val("release_level", {61'd0, level}, 64'd0);

        // 10-beat packet with sink always ready
        m_ready = 1'b1;
        sum = 0;
        for (int i = 1; i <= 10; i++) begin
            send(32'(i), 4'hF, (i == 10), cyc);
            sum += cyc;
        end
        s_valid = 1'b0;
        check_val("stream_cycles", 64'(sum), 64'd10);
        repeat (3) tick();
        check_val("pkt_after_stream", {48'd0, pkt_count}, 64'd1);

        // fill to full with sink stalled, then drain
        m_ready = 1'b0;
        for (int i = 1; i <= 4; i++) send(32'h100 + 32'(i), 4'hF, 1'b0, cyc);
        s_data = 32'h105;
        s_last = 1'b0;
        repeat (2) tick();
        check_val("full_level", {61'd0, level}, 64'd4);
        check_val("full_ready", {63'd0, s_ready}, 64'd0);
        m_ready = 1'b1;
        send(32'h105, 4'hF, 1'b0, cyc);
        send(32'h106, 4'hF, 1'b0, cyc);
        s_valid = 1'b0;
        repeat (6) tick();
        check_val("drain_level", {61'd0, level}, 64'd0);

        // steady push+pop at level 2
        m_ready = 1'b0;
        send(32'h201, 4'h3, 1'b0, cyc);
        send(32'h202, 4'h5, 1'b0, cyc);
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(32'h210 + 32'(i), 4'(i), 1'b0, cyc);
            check_val("steady_level", {61'd0, level}, 64'd2);
        end
        s_valid = 1'b0;
        repeat (4) tick();

        // withdraw valid while full
        m_ready = 1'b0;
        for (int i = 1; i <= 4; i++) send(32'h300 + 32'(i), 4'hF, 1'b0, cyc);
        s_data  = 32'h3FF;
        tick();
        s_valid = 1'b0;
        repeat (2) tick();
        check_val("proto_set", {63'd0, proto_err}, 64'd1);
        m_ready = 1'b1;
        repeat (6) tick();
        check_val("proto_sticky", {63'd0, proto_err}, 64'd1);

        // reset clears proto_err; three 2-beat packets
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        check_val("proto_cleared", {63'd0, proto_err}, 64'd0);
        for (int p = 0; p < 3; p++) begin
            send(32'h400 + 32'(2 * p), 4'h0, 1'b0, cyc);
            send(32'h401 + 32'(2 * p), 4'hF, 1'b1, cyc);
        end
        s_valid = 1'b0;
        repeat (4) tick();
        check_val("pkt_three", {48'd0, pkt_count}, 64'd3);

        // reset in the middle of a fourth packet
        m_ready = 1'b0;
        send(32'h501, 4'hF, 1'b0, cyc);
        s_data = 32'h502;
        tick();
        reset = 1'b1;
        #1;
        check_val("midrst_m_valid", {63'd0, m_valid}, 64'd0);
        check_val("midrst_pkt", {48'd0, pkt_count}, 64'd0);
        check_val("midrst_level", {61'd0, level}, 64'd0);
        s_valid = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        check_val("midrst_ready0", {63'd0, s_ready}, 64'd0);
        tick();
        check_val("midrst_ready1", {63'd0, s_ready}, 64'd1);
        repeat (2) tick();

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
